// File: rtl/stream_seq_checker.sv
// Sequence checker for an incrementing stream: tracks the expected next value,
// counts accepted beats and mismatches, and applies LFSR-driven backpressure.
module stream_seq_checker #(
    parameter int DATA_BITS = 8,
    parameter int STALL_EN  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 clr_err,
    output logic                 err,
    output logic [7:0]           err_count,
    output logic [15:0]          rx_count,
    output logic [DATA_BITS-1:0] last_data
);

    typedef enum logic [0:0] {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } state_e;

    localparam logic [DATA_BITS-1:0] DATA_ONE  = {{(DATA_BITS-1){1'b0}}, 1'b1};
    localparam logic [DATA_BITS-1:0] DATA_ZERO = {DATA_BITS{1'b0}};

    // Maximal-length 8-bit Fibonacci LFSR step (taps 7,5,4,3); never reaches zero.
    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        logic [7:0] res;
        if (val == 8'hFF) begin
            res = 8'hFF;
        end else begin
            res = val + 8'd1;
        end
        return res;
    endfunction

    state_e               state_r;
    state_e               state_s;
    logic [DATA_BITS-1:0] expected_r;
    logic [DATA_BITS-1:0] expected_s;
    logic [7:0]           lfsr_r;
    logic                 err_r;
    logic                 err_s;
    logic [7:0]           err_count_r;
    logic [7:0]           err_count_s;
    logic [15:0]          rx_count_r;
    logic [15:0]          rx_count_s;
    logic [DATA_BITS-1:0] last_data_r;
    logic [DATA_BITS-1:0] last_data_s;
    logic                 in_ready_s;
    logic                 accept_s;
    logic                 mismatch_s;

    // Backpressure from registered LFSR only, forced low while reset is applied.
    always_comb begin
        in_ready_s = 1'b0;
        if (reset) begin
            in_ready_s = 1'b0;
        end else if (STALL_EN != 0) begin
            in_ready_s = (lfsr_r[2:0] != 3'd0);
        end else begin
            in_ready_s = 1'b1;
        end
    end

    assign accept_s = in_valid & in_ready_s;

    // Sequence FSM next state, expected value and beat bookkeeping.
    always_comb begin
        state_s     = state_r;
        expected_s  = expected_r;
        rx_count_s  = rx_count_r;
        last_data_s = last_data_r;
        mismatch_s  = 1'b0;
        if (accept_s) begin
            rx_count_s  = rx_count_r + 16'd1;
            last_data_s = in_data;
            case (state_r)
                SYNC: begin
                    expected_s = in_data + DATA_ONE;
                    state_s    = TRACK;
                end
                TRACK: begin
                    if (in_data == expected_r) begin
                        expected_s = expected_r + DATA_ONE;
                    end else begin
                        mismatch_s = 1'b1;
                        expected_s = in_data + DATA_ONE;
                    end
                end
                default: begin
                    state_s    = SYNC;
                    expected_s = DATA_ZERO;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Error status: a clear in the same cycle as a mismatch yields a fresh count of one.
    always_comb begin
        err_s       = err_r;
        err_count_s = err_count_r;
        if (mismatch_s) begin
            err_s       = 1'b1;
            err_count_s = clr_err ? 8'h01 : sat_inc8(err_count_r);
        end else if (clr_err) begin
            err_s       = 1'b0;
            err_count_s = 8'h00;
        end else begin
            err_s       = err_r;
            err_count_s = err_count_r;
        end
    end

    // State register; the LFSR free-runs every cycle outside reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= SYNC;
            expected_r  <= DATA_ZERO;
            lfsr_r      <= 8'h01;
            err_r       <= 1'b0;
            err_count_r <= 8'h00;
            rx_count_r  <= 16'h0000;
            last_data_r <= DATA_ZERO;
        end else begin
            state_r     <= state_s;
            expected_r  <= expected_s;
            lfsr_r      <= lfsr_step(lfsr_r);
            err_r       <= err_s;
            err_count_r <= err_count_s;
            rx_count_r  <= rx_count_s;
            last_data_r <= last_data_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign err       = err_r;
    assign err_count = err_count_r;
    assign rx_count  = rx_count_r;
    assign last_data = last_data_r;

endmodule

// File: tb/tb_stream_seq_checker.sv
// Scoreboard bench: instance 0 always ready, instance 1 with LFSR backpressure,
// both checked every cycle against a behavioural model.
module tb_stream_seq_checker;

    logic       clk;
    logic       rst0, rst1, vld0, vld1, clr0, clr1;
    logic [7:0] dat0, dat1;
    logic       rdy0, rdy1, err0, err1;
    logic [7:0] ecnt0, ecnt1, last0, last1;
    logic [15:0] rxc0, rxc1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int e_err;
        int e_cnt;
        int e_rx;
        int e_last;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // behavioural model state per instance
    int m_lfsr [2];
    int m_exp  [2];
    bit m_have [2];
    int m_err  [2];
    int m_cnt  [2];
    int m_rx   [2];
    int m_last [2];
    bit m_acc  [2];

    stream_seq_checker #(.DATA_BITS(8), .STALL_EN(0)) u_nostall (
        .clk(clk), .reset(rst0), .in_valid(vld0), .in_ready(rdy0), .in_data(dat0),
        .clr_err(clr0), .err(err0), .err_count(ecnt0), .rx_count(rxc0), .last_data(last0)
    );

    stream_seq_checker #(.DATA_BITS(8), .STALL_EN(1)) u_stall (
        .clk(clk), .reset(rst1), .in_valid(vld1), .in_ready(rdy1), .in_data(dat1),
        .clr_err(clr1), .err(err1), .err_count(ecnt1), .rx_count(rxc1), .last_data(last1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic model_step(input int i, input bit v, input int d, input bit c,
                              input bit r, input bit rdy_act);
        bit   rdy_e;
        exp_t e;
        if (r) rdy_e = 1'b0;
        else if (i == 1) rdy_e = (m_lfsr[i] % 8) != 0;
        else rdy_e = 1'b1;
        chk(i == 0 ? "in_ready0" : "in_ready1", int'(rdy_act), int'(rdy_e));
        m_acc[i] = v && rdy_e;
        if (r) begin
            m_have[i] = 1'b0; m_exp[i] = 0; m_lfsr[i] = 1;
            m_err[i] = 0; m_cnt[i] = 0; m_rx[i] = 0; m_last[i] = 0;
        end else begin
            if (c) begin
                m_err[i] = 0;
                m_cnt[i] = 0;
            end
            if (m_acc[i]) begin
                m_rx[i]   = (m_rx[i] + 1) % 65536;
                m_last[i] = d;
                if (m_have[i] && d != m_exp[i]) begin
                    m_err[i] = 1;
                    m_cnt[i] = (m_cnt[i] < 255) ? m_cnt[i] + 1 : 255;
                end
                m_exp[i]  = (d + 1) % 256;
                m_have[i] = 1'b1;
            end
            m_lfsr[i] = ((m_lfsr[i] * 2) % 256) + ($countones(m_lfsr[i] & 8'hB8) % 2);
        end
        e.e_err = m_err[i]; e.e_cnt = m_cnt[i]; e.e_rx = m_rx[i]; e.e_last = m_last[i];
        if (i == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Called just after a falling edge: predicts the coming rising edge, then waits a cycle.
    task automatic tick();
        #1;
        model_step(0, vld0, int'(dat0), clr0, rst0, rdy0);
        model_step(1, vld1, int'(dat1), clr1, rst1, rdy1);
        @(negedge clk);
    endtask

    task automatic beat0(input int d);
        vld0 = 1'b1;
        dat0 = 8'(d);
        tick();
        vld0 = 1'b0;
    endtask

    task automatic reset0();
        rst0 = 1'b1;
        vld0 = 1'b0;
        tick();
        rst0 = 1'b0;
    endtask

    task automatic dchk(input int i, input int e_err, input int e_cnt,
                        input int e_rx, input int e_last, input string tag);
        if (i == 0) begin
            chk({tag, ".err"}, int'(err0), e_err);
            chk({tag, ".err_count"}, int'(ecnt0), e_cnt);
            chk({tag, ".rx_count"}, int'(rxc0), e_rx);
            chk({tag, ".last_data"}, int'(last0), e_last);
        end else begin
            chk({tag, ".err"}, int'(err1), e_err);
            chk({tag, ".err_count"}, int'(ecnt1), e_cnt);
            chk({tag, ".rx_count"}, int'(rxc1), e_rx);
            chk({tag, ".last_data"}, int'(last1), e_last);
        end
    endtask

    // Scoreboard monitors: one expected entry per modelled cycle.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("mon0.err", int'(err0), e.e_err);
            chk("mon0.err_count", int'(ecnt0), e.e_cnt);
            chk("mon0.rx_count", int'(rxc0), e.e_rx);
            chk("mon0.last_data", int'(last0), e.e_last);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("mon1.err", int'(err1), e.e_err);
            chk("mon1.err_count", int'(ecnt1), e.e_cnt);
            chk("mon1.rx_count", int'(rxc1), e.e_rx);
            chk("mon1.last_data", int'(last1), e.e_last);
        end
    end

    initial begin
        int src;
        int nacc;
        int ncyc;
        int nxt;
        rst0 = 1'b1; rst1 = 1'b1;
        vld0 = 1'b0; vld1 = 1'b0;
        clr0 = 1'b0; clr1 = 1'b0;
        dat0 = 8'h00; dat1 = 8'h00;
        @(negedge clk);
        tick();
        tick();
        rst0 = 1'b0; rst1 = 1'b0;
        dchk(0, 0, 0, 0, 0, "reset0");
        dchk(1, 0, 0, 0, 0, "reset1");

        for (int k = 16; k <= 20; k++) beat0(k);
        dchk(0, 0, 0, 5, 8'h14, "incr");

        reset0();
        beat0(8'hFE); beat0(8'hFF); beat0(8'h00); beat0(8'h01);
        dchk(0, 0, 0, 4, 8'h01, "wrap");

        reset0();
        beat0(8'h05); beat0(8'h06); beat0(8'h09);
        dchk(0, 1, 1, 3, 8'h09, "gap");
        beat0(8'h0A);
        dchk(0, 1, 1, 4, 8'h0A, "gap_resync");
        clr0 = 1'b1; tick(); clr0 = 1'b0;
        dchk(0, 0, 0, 4, 8'h0A, "clr");

        reset0();
        for (int k = 0; k < 300; k++) beat0(8'h00);
        dchk(0, 1, 255, 300, 0, "sat");
        clr0 = 1'b1; tick(); clr0 = 1'b0;
        dchk(0, 0, 0, 300, 0, "sat_clr");
        clr0 = 1'b1; beat0(8'h00); clr0 = 1'b0;
        dchk(0, 1, 1, 301, 0, "clr_and_mismatch");

        reset0();
        beat0(8'h1F); beat0(8'h20);
        rst0 = 1'b1; vld0 = 1'b1; dat0 = 8'h21; tick(); rst0 = 1'b0;
        beat0(8'h80); beat0(8'h81);
        dchk(0, 0, 0, 2, 8'h81, "midreset");

        // randomized always-ready traffic with occasional jumps and clears
        nxt = 0;
        for (int k = 0; k < 500; k++) begin
            vld0 = ($urandom_range(0, 3) != 0);
            dat0 = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'(nxt);
            clr0 = ($urandom_range(0, 15) == 0);
            tick();
            if (m_acc[0]) nxt = (int'(dat0) + 1) % 256;
        end
        vld0 = 1'b0; clr0 = 1'b0;

        // backpressured incrementing source, advancing only on acceptance
        rst1 = 1'b1; tick(); rst1 = 1'b0;
        src = $urandom_range(0, 255);
        nacc = 0;
        ncyc = 0;
        vld1 = 1'b1;
        while (nacc < 1000 && ncyc < 4000) begin
            dat1 = 8'(src);
            tick();
            ncyc++;
            if (m_acc[1]) begin
                src = (src + 1) % 256;
                nacc++;
            end
        end
        vld1 = 1'b0;
        chk("stall_beats", nacc, 1000);
        dchk(1, 0, 0, 1000, (src + 255) % 256, "stall");

        nxt = 0;
        for (int k = 0; k < 300; k++) begin
            vld1 = ($urandom_range(0, 1) != 0);
            dat1 = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255)) : 8'(nxt);
            clr1 = ($urandom_range(0, 19) == 0);
            tick();
            if (m_acc[1]) nxt = (int'(dat1) + 1) % 256;
        end
        vld1 = 1'b0; clr1 = 1'b0;

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q0.size() + q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_seq_checker.md
STREAM_SEQ_CHECKER -- requirements
Module: stream_seq_checker

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: width of the stream data.
REQ-002 SHALL have parameter STALL_EN, default 1: 1 enables pseudo-random backpressure; 0 makes the block always ready.
REQ-003 SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset, sampled on the clk rising edge.
REQ-005 SHALL have port in_valid  input  1: upstream (skid buffer output) beat valid.
REQ-006 SHALL have port in_ready  output  1: block accepts a beat this cycle.
REQ-007 SHALL have port in_data  input  DATA_BITS: beat payload.
REQ-008 SHALL have port clr_err  input  1: synchronous clear of error status.
REQ-009 SHALL have port err  output  1: sticky, set on any sequence mismatch.
REQ-010 SHALL have port err_count  output  8: mismatch count, saturating.
REQ-011 SHALL have port rx_count  output  16: accepted-beat count, wrapping.
REQ-012 SHALL have port last_data  output  DATA_BITS: payload of the most recently accepted beat.

Function
REQ-013 SHALL define a beat as accepted in a cycle where in_valid && in_ready at the rising edge.
REQ-014 SHALL hold an 8-bit LFSR: seed 8'h01; every cycle next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}; it never reaches 0.
REQ-015 SHALL drive in_ready combinationally from registered state only: STALL_EN=0 -> 1 whenever not in reset; STALL_EN=1 -> (lfsr[2:0] != 0); in_ready SHALL NOT depend on in_valid.
REQ-016 SHALL drive in_ready = 0 in any cycle where reset is high.
REQ-017 SHALL implement a two-state FSM: SYNC (no expected value yet) and TRACK.
REQ-018 SYNC: on acceptance, expected <= in_data + 1 (mod 2^DATA_BITS), go to TRACK; no mismatch is ever flagged in SYNC.
REQ-019 TRACK: on acceptance with in_data == expected, expected <= expected + 1, with 2^DATA_BITS-1 wrapping to 0.
REQ-020 TRACK: on acceptance with in_data != expected, set err, increment err_count, and resync expected <= in_data + 1; remain in TRACK.
REQ-021 SHALL saturate err_count at 8'hFF; further mismatches still set err.
REQ-022 SHALL increment rx_count by 1 per accepted beat, wrapping 16'hFFFF -> 0; clr_err SHALL NOT affect it.
REQ-023 SHALL load last_data <= in_data on every accepted beat and hold it otherwise.
REQ-024 clr_err SHALL clear err and err_count in the following cycle; FSM, expected, rx_count and last_data are unaffected.
REQ-025 clr_err and a mismatch in the same cycle: clear is applied first, then the mismatch, giving err = 1 and err_count = 1.
REQ-026 Cycles with in_valid high and in_ready low SHALL change no state except the LFSR.
REQ-027 All outputs except in_ready SHALL be registered; latency from acceptance to updated err, err_count, rx_count and last_data SHALL be 1 cycle.

Reset
REQ-028 On reset: FSM = SYNC, expected = 0, lfsr = 8'h01, err = 0, err_count = 0, rx_count = 0, last_data = 0.
REQ-029 Reset asserted mid-stream SHALL discard any beat presented in that cycle and return to SYNC; the first beat accepted after reset resynchronises the sequence without flagging an error.

Verification
REQ-030 STALL_EN=0; after reset, send 0x10..0x14 back to back -> rx_count = 5, last_data = 0x14, err = 0, err_count = 0.
REQ-031 STALL_EN=0; send 0xFE, 0xFF, 0x00, 0x01 -> no error (wrap case); rx_count = 4.
REQ-032 STALL_EN=0; send 0x05, 0x06, 0x09, 0x0A -> err = 1 one cycle after 0x09 is accepted, err_count = 1; 0x0A is accepted with no second error.
REQ-033 STALL_EN=0; 300 mismatching beats (alternating 0x00, 0x00) -> err_count saturates at 0xFF; pulse clr_err -> err = 0, err_count = 0, rx_count = 300.
REQ-034 STALL_EN=1; hold in_valid high with an incrementing source that advances only on acceptance -> in_ready low exactly on cycles where lfsr[2:0] = 0; no beat is lost or duplicated; err = 0 after 1000 beats.
REQ-035 Assert reset mid-stream after 0x20, then send 0x80, 0x81 -> err = 0, rx_count = 2, last_data = 0x81.
